// File: rtl/proj_pkg.sv
// rtl/proj_pkg.sv - shared FM/MinHash constants and types
package proj_pkg;

  localparam int FM_DATA_BITS              = 2;
  localparam int FM_EXTENDER_FRAG_LEN_BITS = 8;
  localparam int FM_RAMS_COUNT             = 2;
  localparam int FM_ENTRIES_COUNT          = 2;
  localparam int FM_OFFSET_COUNT           = 4;
  localparam int SIGNED_INDICE_LEN         = 8;

  localparam int          MH_HASH_BITS = 32;
  localparam logic [31:0] MH_HASH_MULT = 32'h9E3779B1;

  typedef enum logic [2:0] {IDLE, SWAP, SCAN, DRAIN, REPORT} mh_state_t;
  typedef logic [MH_HASH_BITS-1:0] mh_hash_t;

endpackage

// File: rtl/proj_mh_hash_unit.sv
// rtl/proj_mh_hash_unit.sv - two-stage registered multiply/xor-fold fragment hash
module proj_mh_hash_unit
  import proj_pkg::*;
#(
  parameter int                   FRAG_LEN  = FM_EXTENDER_FRAG_LEN_BITS,
  parameter int                   POS_BITS  = SIGNED_INDICE_LEN,
  parameter int                   HASH_BITS = MH_HASH_BITS,
  parameter logic [HASH_BITS-1:0] HASH_MULT = MH_HASH_MULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [FRAG_LEN-1:0]  in_data,
  input  logic [POS_BITS-1:0]  in_pos,
  output logic                 out_valid,
  output logic [HASH_BITS-1:0] out_hash,
  output logic [POS_BITS-1:0]  out_pos
);

  logic                 s1_valid;
  logic [FRAG_LEN-1:0]  s1_data;
  logic [POS_BITS-1:0]  s1_pos;
  logic [HASH_BITS-1:0] prod;
  logic [HASH_BITS-1:0] fold;

  // Product is truncated to HASH_BITS; the fold mixes high bits back into the low half.
  always_comb begin
    prod = HASH_BITS'(s1_data) * HASH_MULT;
    fold = prod ^ (prod >> (HASH_BITS / 2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_pos    <= '0;
      out_valid <= 1'b0;
      out_hash  <= '0;
      out_pos   <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_data   <= in_data;
      s1_pos    <= in_pos;
      out_valid <= s1_valid;
      out_hash  <= fold;
      out_pos   <= s1_pos;
    end
  end

endmodule

// File: rtl/proj_fm_minhash.sv
// rtl/proj_fm_minhash.sv - FM buffer sweep producing a MinHash element; PROJ_MH_PAD_EN adds left-padded windows
module proj_fm_minhash
  import proj_pkg::*;
#(
  parameter int                   DATA_BITS         = FM_DATA_BITS,
  parameter int                   FRAG_LEN          = FM_EXTENDER_FRAG_LEN_BITS,
  parameter int                   BUF_SYMS          = FM_RAMS_COUNT * FM_ENTRIES_COUNT * FM_OFFSET_COUNT,
  parameter int                   SIGNED_INDICE_LEN = proj_pkg::SIGNED_INDICE_LEN,
  parameter int                   HASH_BITS         = MH_HASH_BITS,
  parameter logic [HASH_BITS-1:0] HASH_MULT         = MH_HASH_MULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         fm_wait,
  input  logic [FRAG_LEN-1:0]          fm_rdata,
  output logic                         chg_idx,
  output logic [SIGNED_INDICE_LEN-1:0] frag_idx,
  output logic                         mh_valid,
  input  logic                         mh_ready,
  output logic [HASH_BITS-1:0]         mh_hash,
  output logic [SIGNED_INDICE_LEN-1:0] mh_pos,
  output logic                         busy
);

  localparam int FRAG_SYMS = FRAG_LEN / DATA_BITS;
`ifdef PROJ_MH_PAD_EN
  localparam int START = -(FRAG_SYMS - 1);
`else
  localparam int START = 0;
`endif
  localparam int END_POS = BUF_SYMS - FRAG_SYMS;
  localparam logic [SIGNED_INDICE_LEN-1:0] START_IDX = SIGNED_INDICE_LEN'(START);
  localparam logic [SIGNED_INDICE_LEN-1:0] END_IDX   = SIGNED_INDICE_LEN'(END_POS);

  mh_state_t                    state, state_nxt;
  logic                         drain_cnt;
  logic [HASH_BITS-1:0]         min_hash;
  logic [SIGNED_INDICE_LEN-1:0] min_pos;
  logic                         h_valid;
  logic [HASH_BITS-1:0]         h_hash;
  logic [SIGNED_INDICE_LEN-1:0] h_pos;

  proj_mh_hash_unit #(
    .FRAG_LEN  (FRAG_LEN),
    .POS_BITS  (SIGNED_INDICE_LEN),
    .HASH_BITS (HASH_BITS),
    .HASH_MULT (HASH_MULT)
  ) u_hash (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (state == SCAN),
    .in_data   (fm_rdata),
    .in_pos    (frag_idx),
    .out_valid (h_valid),
    .out_hash  (h_hash),
    .out_pos   (h_pos)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && fm_wait) state_nxt = SWAP;
      SWAP:    state_nxt = SCAN;
      SCAN:    if (frag_idx == END_IDX) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = REPORT;
      REPORT:  if (mh_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    chg_idx  = 1'b0;
    mh_valid = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE:    busy = 1'b0;
      SWAP:    chg_idx = 1'b1;
      REPORT:  mh_valid = 1'b1;
      default: ;
    endcase
  end

  // Strict less-than in S3 keeps the earliest position on equal hashes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frag_idx  <= '0;
      drain_cnt <= 1'b0;
      min_hash  <= '1;
      min_pos   <= '0;
    end else begin
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (h_valid && (h_hash < min_hash)) begin
        min_hash <= h_hash;
        min_pos  <= h_pos;
      end
      case (state)
        SWAP: begin
          frag_idx <= START_IDX;
          min_hash <= '1;
          min_pos  <= START_IDX;
        end
        SCAN:    if (frag_idx != END_IDX) frag_idx <= frag_idx + SIGNED_INDICE_LEN'(1);
        default: ;
      endcase
    end
  end

  assign mh_hash = min_hash;
  assign mh_pos  = min_pos;

endmodule

// File: doc/proj_fm_minhash.md
Name: proj_fm_minhash

Overview:
- Downstream consumer of the double-buffered FM stage.
- Waits until the FM write side reports a full buffer (out_wait), pulses chg_idx to swap buffers, then sweeps frag_idx across the new read buffer one symbol per cycle.
- Hashes every returned fragment and reports the minimum hash and its symbol position (MinHash sketch element) with a valid/ready handshake.

Parameters:
- DATA_BITS, proj_pkg::FM_DATA_BITS (2): bits per symbol.
- FRAG_LEN, proj_pkg::FM_EXTENDER_FRAG_LEN_BITS: fragment width in bits. FRAG_SYMS = FRAG_LEN/DATA_BITS.
- BUF_SYMS, proj_pkg::FM_RAMS_COUNT*FM_ENTRIES_COUNT*FM_OFFSET_COUNT: symbols per FM buffer.
- SIGNED_INDICE_LEN, proj_pkg::SIGNED_INDICE_LEN: width of frag_idx and position.
- HASH_BITS, proj_pkg::MH_HASH_BITS (32): hash width.
- HASH_MULT, proj_pkg::MH_HASH_MULT (32'h9E3779B1): odd multiplicative constant.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset. Asynchronous, active-low.
- enable, input, 1: permits a new scan to begin. Sampled only in IDLE.
- fm_wait, input, 1: FM out_wait. High means the write buffer is full.
- fm_rdata, input, FRAG_LEN: FM out_rdata. Combinational response to frag_idx in the same cycle.
- chg_idx, output, 1: one-cycle buffer-swap pulse to FM.
- frag_idx, output, SIGNED_INDICE_LEN: fragment start position (symbols, signed) to FM.
- mh_valid, output, 1: result valid.
- mh_ready, input, 1: result accepted.
- mh_hash, output, HASH_BITS: minimum hash of the scanned buffer.
- mh_pos, output, SIGNED_INDICE_LEN: frag_idx that produced mh_hash.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset values: chg_idx=0, frag_idx=0, mh_valid=0, mh_hash=all-ones, mh_pos=0, busy=0. FSM goes to IDLE and pipeline valids clear. Reset is honoured mid-scan; the partial result is discarded.
- FSM states and transitions:
  - IDLE: if enable && fm_wait, go to SWAP.
  - SWAP: chg_idx=1 for exactly this cycle. Load frag_idx=START, min=all-ones, go to SCAN.
  - SCAN: drive frag_idx. Increment by 1 each cycle. The cycle that drives END goes to DRAIN.
  - DRAIN: 2 cycles, flushing the pipeline.
  - REPORT: mh_valid=1; mh_hash and mh_pos stay stable until mh_ready. On mh_valid && mh_ready, go to IDLE in the next cycle.
- Scan range: START=0, END=BUF_SYMS-FRAG_SYMS, giving N_POS=END-START+1 fragments.
- Pipeline, 3 stages:
  - S1 registers fm_rdata and frag_idx at the SCAN edge.
  - S2 computes p = zero-extended fragment * HASH_MULT mod 2^HASH_BITS, then h = p ^ (p >> HASH_BITS/2). S2 registers h and its position.
  - S3 compares: if h < min (strict), update min and pos. Ties keep the earlier position.
- Timing: with the SWAP cycle as cycle 0, SCAN occupies cycles 1..N_POS, DRAIN occupies N_POS+1..N_POS+2, and mh_valid first rises in cycle N_POS+3.
- enable is ignored outside IDLE; a scan in progress always completes.
- fm_wait low in IDLE means stay in IDLE, with chg_idx never asserted.
- fm_wait changes during SCAN are ignored.
- Backpressure: while in REPORT, no new SWAP occurs. FM holds via its own out_wait.
- frag_idx holds its last value outside SCAN.

Optional Feature:
- Macro: PROJ_MH_PAD_EN.
- When defined: START = -(FRAG_SYMS-1), so edge fragments left-padded with zeros by FM are included. N_POS = BUF_SYMS; mh_pos may be negative.
- When undefined: START = 0, as described in Behaviour.

Decomposition:
- Add to proj_pkg:
  - MH_HASH_BITS and MH_HASH_MULT.
  - typedef enum mh_state_t {IDLE, SWAP, SCAN, DRAIN, REPORT}.
  - typedef logic [MH_HASH_BITS-1:0] mh_hash_t.
- One sub-module, proj_mh_hash_unit: the S1/S2 registered multiply-xorfold stage. Interface: valid/data/position in, valid/hash/position out, fixed 2-cycle latency.

Test Plan:
- Basic scan. Bench config BUF_SYMS=16, FRAG_SYMS=4; buffer filled with all-zero symbols except one nonzero fragment at positions 5..8.
  - Required: single chg_idx pulse, frag_idx steps 0..12.
  - mh_valid rises 16 cycles after the pulse, with mh_hash=0 and mh_pos=0 (tie rule keeps the earliest).
- Reference-model scan: random buffer contents.
  - Required: mh_hash and mh_pos match a software model of the hash over positions 0..12, strict-min, earliest on tie.
- Gating.
  - enable=1, fm_wait=0 for 50 cycles: chg_idx stays 0, busy=0.
  - enable=0, fm_wait=1: same result.
- Backpressure: hold mh_ready=0 for 20 cycles in REPORT while fm_wait=1.
  - Required: outputs stable, no chg_idx.
  - Then mh_ready=1: IDLE next cycle, SWAP the cycle after.
- Reset mid-scan: assert rst_n=0 at frag_idx=7.
  - Required: all outputs take reset values immediately, no mh_valid.
  - A rescan after release produces the correct result.
- PROJ_MH_PAD_EN: minimum placed in a padded window.
  - Required: frag_idx starts at -3 and ends at 12; mh_pos=-3 is reported.
